// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wash_pkg
// Brief    : Shared definitions for the washing-machine front panel:
//            program codes, panel state encoding and program helpers.
// Revision : 1.0 - initial release
// ============================================================================
package wash_pkg;

    // Program codes understood by FSMW
    typedef enum logic [2:0] {
        COLD_WASH   = 3'b000,
        HOT_WASH    = 3'b001,
        RINSING_DRY = 3'b010,
        ONLY_DRY    = 3'b011
    } prog_t;

    // Panel controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } panel_state_t;

    // Wash programs need detergent; the drying-only programs do not
    function automatic logic soap_required(input prog_t prog);
        return (prog == COLD_WASH) || (prog == HOT_WASH);
    endfunction

    // Cycle through the four programs, wrapping ONLY_DRY back to COLD_WASH
    function automatic prog_t next_program(input prog_t prog);
        logic [1:0] low;
        low = prog[1:0] + 2'd1;
        return prog_t'({1'b0, low});
    endfunction

endpackage
`default_nettype wire

// File: rtl/panel_debounce.sv
`default_nettype none
// ============================================================================
// Module   : panel_debounce
// Brief    : Two-flop synchronizer followed by a stability filter; emits a
//            one-cycle pulse when the accepted level goes from 0 to 1.
// Revision : 1.0 - initial release
// ============================================================================
module panel_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] c_deb_last = 8'(DEB_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_level;
    logic       r_rise;
    logic [7:0] r_cnt;

    // Synchronize, then accept a new level only after DEB_CYCLES differing samples in a row
    always_ff @(posedge clk) begin
        if (clr) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == c_deb_last) begin
                r_level <= r_s2;
                r_cnt   <= 8'd0;
                r_rise  <= r_s2;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/wash_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wash_panel_ctrl
// Brief    : Front-panel controller for FSMW. Debounces buttons, latches the
//            program, synchronizes door/soap sensors, issues start and tracks
//            the run through completion.
//            Optional macro WASH_PANEL_CYCLE_COUNT_EN enables the saturating
//            completed-program counter on cycle_count.
// Revision : 1.0 - initial release
// ============================================================================
module wash_panel_ctrl
    import wash_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int ARM_TIMEOUT = 200,
    parameter int BEEP_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power,
    input  logic        btn_next,
    input  logic        btn_start,
    input  logic        door_raw,
    input  logic        soap_raw,
    input  logic        program_done,
    input  logic [7:0]  timer_display,
    output logic [2:0]  program_selection,
    output logic        start,
    output logic        doorclosed,
    output logic        soap,
    output logic        door_lock,
    output logic [7:0]  disp_value,
    output logic        done_beep,
    output logic        arm_fail,
    output logic [15:0] cycle_count
);

    localparam logic [15:0] c_arm_last  = 16'(ARM_TIMEOUT - 1);
    localparam logic [7:0]  c_beep_last = 8'(BEEP_CYCLES - 1);

    // Power loss behaves exactly like reset
    logic w_clr;
    assign w_clr = rst | ~power;

    panel_state_t r_state;
    panel_state_t w_state_next;
    prog_t        r_sel;
    logic         r_door_s1, r_door_s2;
    logic         r_soap_s1, r_soap_s2;
    logic         r_start, r_arm_fail, r_pd_d;
    logic [15:0]  r_arm_timer;
    logic [7:0]   r_beep_timer;
    logic         w_ev_next, w_ev_start;
    logic         w_go, w_timeout, w_pd_rise, w_soap_ok;

    panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk  (clk),
        .clr  (w_clr),
        .raw  (btn_next),
        .rise (w_ev_next)
    );

    panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk  (clk),
        .clr  (w_clr),
        .raw  (btn_start),
        .rise (w_ev_start)
    );

    assign w_pd_rise = program_done & ~r_pd_d;
    assign w_soap_ok = r_soap_s2 | ~soap_required(r_sel);

    // State register; start/arm_fail are registered alongside so they coincide with the new state
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_arm_fail <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_start    <= w_go;
            r_arm_fail <= w_timeout;
        end
    end

    // Next-state logic; in ARMED, launch beats cancel, and cancel beats timeout
    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_start) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (r_door_s2 && w_soap_ok) begin
                    w_go         = 1'b1;
                    w_state_next = ST_RUNNING;
                end else if (w_ev_start) begin
                    w_state_next = ST_IDLE;
                end else if (r_arm_timer == c_arm_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (w_pd_rise) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_ev_next || (r_beep_timer == c_beep_last)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        door_lock  = 1'b0;
        disp_value = 8'd0;
        done_beep  = 1'b0;
        case (r_state)
            ST_RUNNING: begin
                door_lock  = 1'b1;
                disp_value = timer_display;
            end
            ST_DONE:    done_beep = 1'b1;
            default:    ;
        endcase
    end

    // Sensor synchronizers, program_done history, dwell timers and program selection
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_door_s1    <= 1'b0;
            r_door_s2    <= 1'b0;
            r_soap_s1    <= 1'b0;
            r_soap_s2    <= 1'b0;
            r_pd_d       <= 1'b0;
            r_arm_timer  <= 16'd0;
            r_beep_timer <= 8'd0;
            r_sel        <= COLD_WASH;
        end else begin
            r_door_s1    <= door_raw;
            r_door_s2    <= r_door_s1;
            r_soap_s1    <= soap_raw;
            r_soap_s2    <= r_soap_s1;
            r_pd_d       <= program_done;
            r_arm_timer  <= (r_state == ST_ARMED) ? r_arm_timer + 16'd1 : 16'd0;
            r_beep_timer <= (r_state == ST_DONE) ? r_beep_timer + 8'd1 : 8'd0;
            if ((r_state == ST_IDLE) && w_ev_next) r_sel <= next_program(r_sel);
        end
    end

`ifdef WASH_PANEL_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    // Count completed programs, holding at the maximum
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cycle_count <= 16'd0;
        end else if ((r_state == ST_RUNNING) && w_pd_rise && (r_cycle_count != 16'hFFFF)) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 16'd0;
`endif

    assign program_selection = r_sel;
    assign start             = r_start;
    assign arm_fail          = r_arm_fail;
    assign doorclosed        = r_door_s2;
    assign soap              = r_soap_s2;

endmodule
`default_nettype wire

// File: tb/tb_wash_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_panel_ctrl
// Brief    : Self-checking bench for wash_panel_ctrl: table of program/sensor
//            scenarios plus directed sequences for timeout, ignore-in-run,
//            power loss, pre-high program_done and early beep exit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_panel_ctrl;
    import wash_pkg::*;

    localparam int DEB  = 4;
    localparam int ARM  = 200;
    localparam int BEEP = 20;

    logic        clk = 1'b0;
    logic        rst, power, btn_next, btn_start, door_raw, soap_raw, program_done;
    logic [7:0]  timer_display;
    logic [2:0]  program_selection;
    logic        start, doorclosed, soap, door_lock, done_beep, arm_fail;
    logic [7:0]  disp_value;
    logic [15:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start_seen = 0;
    int n_fail_seen  = 0;

    always #5 clk = ~clk;

    wash_panel_ctrl #(.DEB_CYCLES(DEB), .ARM_TIMEOUT(ARM), .BEEP_CYCLES(BEEP)) dut (
        .clk               (clk),
        .rst               (rst),
        .power             (power),
        .btn_next          (btn_next),
        .btn_start         (btn_start),
        .door_raw          (door_raw),
        .soap_raw          (soap_raw),
        .program_done      (program_done),
        .timer_display     (timer_display),
        .program_selection (program_selection),
        .start             (start),
        .doorclosed        (doorclosed),
        .soap              (soap),
        .door_lock         (door_lock),
        .disp_value        (disp_value),
        .done_beep         (done_beep),
        .arm_fail          (arm_fail),
        .cycle_count       (cycle_count)
    );

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (start)    n_start_seen++;
        if (arm_fail) n_fail_seen++;
    end

    typedef struct {
        int   presses;
        logic soap_v;
        logic door_v;
        int   exp_sel;
        int   exp_start;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit is_start, input int hold);
        if (is_start) btn_start = 1'b1; else btn_next = 1'b1;
        tick(hold);
        btn_start = 1'b0;
        btn_next  = 1'b0;
        tick(10);
    endtask

    task automatic power_cycle();
        power = 1'b0;
        tick(2);
        power = 1'b1;
        tick(3);
    endtask

    // Count done_beep cycles until it drops (bounded)
    task automatic count_beep(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (done_beep) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    int exp_cc;
    int s0, f0, beeps, k;

    initial begin
`ifdef WASH_PANEL_CYCLE_COUNT_EN
        exp_cc = 1;
`else
        exp_cc = 0;
`endif
        vecs[0] = '{0, 1'b0, 1'b1, 0, 0};
        vecs[1] = '{0, 1'b1, 1'b1, 0, 1};
        vecs[2] = '{1, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{1, 1'b1, 1'b1, 1, 1};
        vecs[4] = '{2, 1'b0, 1'b1, 2, 1};
        vecs[5] = '{3, 1'b0, 1'b1, 3, 1};
        vecs[6] = '{4, 1'b0, 1'b1, 0, 0};
        vecs[7] = '{2, 1'b1, 1'b0, 2, 0};

        rst = 1'b1; power = 1'b1; btn_next = 1'b0; btn_start = 1'b0;
        door_raw = 1'b1; soap_raw = 1'b1; program_done = 1'b0; timer_display = 8'd55;
        tick(4);
        // Reset state
        check("reset_sel",   program_selection, 0);
        check("reset_door",  doorclosed, 0);
        check("reset_soap",  soap, 0);
        check("reset_outs",  {start, door_lock, done_beep, arm_fail}, 0);
        check("reset_disp",  disp_value, 0);
        check("reset_cc",    cycle_count, 0);
        rst = 1'b0;
        tick(4);
        check("sync_door", doorclosed, 1);

        // Glitch press shorter than the debounce window
        btn_next = 1'b1; tick(2); btn_next = 1'b0; tick(10);
        check("glitch_sel", program_selection, 0);

        // Table: selection, soap/door gating, full run or cancel
        for (int v = 0; v < 8; v++) begin
            power_cycle();
            door_raw = vecs[v].door_v;
            soap_raw = vecs[v].soap_v;
            for (int p = 0; p < vecs[v].presses; p++) press(1'b0, 10);
            check($sformatf("v%0d_sel", v), program_selection, vecs[v].exp_sel);
            s0 = n_start_seen; f0 = n_fail_seen;
            press(1'b1, 10);
            check($sformatf("v%0d_start", v), n_start_seen - s0, vecs[v].exp_start);
            if (vecs[v].exp_start != 0) begin
                check($sformatf("v%0d_lock", v), door_lock, 1);
                timer_display = 8'd37;
                tick(1);
                check($sformatf("v%0d_disp", v), disp_value, 37);
                program_done = 1'b1;
                count_beep(beeps);
                program_done = 1'b0;
                check($sformatf("v%0d_beep", v), beeps, BEEP);
                check($sformatf("v%0d_cc", v), cycle_count, exp_cc);
                check($sformatf("v%0d_idle", v), (dut.r_state == ST_IDLE), 1);
                check($sformatf("v%0d_disp0", v), disp_value, 0);
            end else begin
                check($sformatf("v%0d_armed", v), (dut.r_state == ST_ARMED), 1);
                press(1'b1, 10);
                check($sformatf("v%0d_cancel", v), (dut.r_state == ST_IDLE), 1);
                check($sformatf("v%0d_nofail", v), n_fail_seen - f0, 0);
                check($sformatf("v%0d_nostart", v), n_start_seen - s0, 0);
            end
        end

        // Arm timeout: exact dwell in ARMED, single arm_fail
        power_cycle();
        door_raw = 1'b1; soap_raw = 1'b0;
        s0 = n_start_seen; f0 = n_fail_seen;
        btn_start = 1'b1;
        k = 0;
        while (dut.r_state != ST_ARMED && k < 50) begin tick(1); k++; end
        check("to_enter_armed", (dut.r_state == ST_ARMED), 1);
        btn_start = 1'b0;
        k = 0;
        while (!arm_fail && k < ARM + 20) begin tick(1); k++; end
        check("to_latency", k, ARM);
        check("to_idle", (dut.r_state == ST_IDLE), 1);
        tick(5);
        check("to_fail_once", n_fail_seen - f0, 1);
        check("to_nostart", n_start_seen - s0, 0);

        // RUNNING ignores buttons; power drop clears everything
        power_cycle();
        soap_raw = 1'b0;
        for (int p = 0; p < 3; p++) press(1'b0, 10);
        press(1'b1, 10);
        check("run_lock", door_lock, 1);
        press(1'b0, 10);
        press(1'b1, 10);
        check("run_sel_kept", program_selection, 3);
        check("run_state_kept", (dut.r_state == ST_RUNNING), 1);
        power = 1'b0;
        tick(1);
        power = 1'b1;
        check("pwr_idle", (dut.r_state == ST_IDLE), 1);
        check("pwr_outs", {program_selection, start, doorclosed, soap, door_lock, done_beep, arm_fail}, 0);
        check("pwr_disp", disp_value, 0);
        check("pwr_cc", cycle_count, 0);

        // program_done already high on entry does not finish; early beep exit keeps selection
        tick(3);
        press(1'b0, 10);
        press(1'b0, 10);
        program_done = 1'b1;
        press(1'b1, 10);
        tick(10);
        check("pd_high_stays_run", (dut.r_state == ST_RUNNING), 1);
        program_done = 1'b0;
        tick(2);
        program_done = 1'b1;
        btn_next = 1'b1;
        count_beep(beeps);
        btn_next = 1'b0;
        program_done = 1'b0;
        check("early_beep_len", beeps, 6);
        check("early_idle", (dut.r_state == ST_IDLE), 1);
        tick(12);
        check("early_sel_kept", program_selection, 2);
        check("early_cc", cycle_count, exp_cc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
